// File: rtl/fft_n64_digit_reverse_buf.sv
// Ping-pong reorder buffer behind the 64-point radix-4 FFT: frames are written at
// digit-reversed addresses and streamed out in natural bin order over valid/ready.
module fft_n64_digit_reverse_buf #(
  parameter int DATA_WIDTH = 33
) (
  input  logic                         sys_clk_i,
  input  logic                         rst_i,
  input  logic                         din_valid_i,
  input  logic                         din_sof_i,
  input  logic signed [DATA_WIDTH-1:0] din_real_i,
  input  logic signed [DATA_WIDTH-1:0] din_imag_i,
  output logic                         dout_valid_o,
  input  logic                         dout_ready_i,
  output logic                         dout_sof_o,
  output logic                         dout_eof_o,
  output logic signed [DATA_WIDTH-1:0] dout_real_o,
  output logic signed [DATA_WIDTH-1:0] dout_imag_o,
  output logic                         ovf_o,
  output logic                         sof_err_o
);

  typedef enum logic {W_IDLE, W_FILL}   w_state_t;
  typedef enum logic {R_IDLE, R_STREAM} r_state_t;

  // Swapping the three base-4 digits maps sample index n to its bin address.
  function automatic logic [5:0] digit_rev(input logic [5:0] n);
    return {n[1:0], n[3:2], n[5:4]};
  endfunction

  w_state_t w_state_q, w_state_d;
  r_state_t r_state_q, r_state_d;
  logic [5:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic       wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [1:0] full_q, full_d;
  logic       ovf_q, ovf_d, sof_err_q, sof_err_d;
  logic       dout_valid_q, dout_valid_d, dout_sof_q, dout_sof_d, dout_eof_q, dout_eof_d;
  logic signed [DATA_WIDTH-1:0] dout_real_q, dout_real_d, dout_imag_q, dout_imag_d;

  logic       wr_en;
  logic [5:0] wr_addr;
  logic       rd_load, rd_sel, rd_release, bank_free;
  logic [5:0] rd_addr;

  logic signed [DATA_WIDTH-1:0] mem_re [2][64];
  logic signed [DATA_WIDTH-1:0] mem_im [2][64];

  // Final sample of the bank under readout is accepted on this edge.
  assign rd_release = dout_valid_q && dout_ready_i && dout_eof_q;
  assign bank_free  = !full_q[wr_bank_q] || (rd_release && (rd_bank_q == wr_bank_q));

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves a latch behind.
    w_state_d = w_state_q;
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    full_d    = full_q;
    ovf_d     = 1'b0;
    sof_err_d = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = digit_rev(wr_cnt_q);
    if (rd_release) full_d[rd_bank_q] = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (din_valid_i && din_sof_i) begin
          if (bank_free) begin
            wr_en     = 1'b1;
            wr_addr   = 6'd0;
            wr_cnt_d  = 6'd1;
            w_state_d = W_FILL;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      W_FILL: begin
        if (din_valid_i) begin
          wr_en = 1'b1;
          if (din_sof_i) begin
            sof_err_d = 1'b1;
            wr_addr   = 6'd0;
            wr_cnt_d  = 6'd1;
          end else begin
            wr_cnt_d = wr_cnt_q + 6'd1;
            if (wr_cnt_q == 6'd63) begin
              full_d[wr_bank_q] = 1'b1;
              wr_bank_d         = ~wr_bank_q;
              w_state_d         = W_IDLE;
            end
          end
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d    = r_state_q;
    rd_cnt_d     = rd_cnt_q;
    rd_bank_d    = rd_bank_q;
    dout_valid_d = dout_valid_q;
    dout_sof_d   = dout_sof_q;
    dout_eof_d   = dout_eof_q;
    rd_load      = 1'b0;
    rd_addr      = rd_cnt_q;
    rd_sel       = rd_bank_q;
    case (r_state_q)
      R_IDLE: begin
        if (full_q[rd_bank_q]) begin
          rd_load      = 1'b1;
          rd_addr      = 6'd0;
          dout_valid_d = 1'b1;
          dout_sof_d   = 1'b1;
          dout_eof_d   = 1'b0;
          rd_cnt_d     = 6'd1;
          r_state_d    = R_STREAM;
        end
      end
      R_STREAM: begin
        if (dout_valid_q && dout_ready_i) begin
          if (dout_eof_q) begin
            rd_bank_d = ~rd_bank_q;
            if (full_q[~rd_bank_q]) begin
              rd_load    = 1'b1;
              rd_sel     = ~rd_bank_q;
              rd_addr    = 6'd0;
              dout_sof_d = 1'b1;
              dout_eof_d = 1'b0;
              rd_cnt_d   = 6'd1;
            end else begin
              dout_valid_d = 1'b0;
              dout_sof_d   = 1'b0;
              dout_eof_d   = 1'b0;
              r_state_d    = R_IDLE;
            end
          end else begin
            rd_load    = 1'b1;
            dout_sof_d = 1'b0;
            dout_eof_d = (rd_cnt_q == 6'd63);
            rd_cnt_d   = rd_cnt_q + 6'd1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    dout_real_d = rd_load ? mem_re[rd_sel][rd_addr] : dout_real_q;
    dout_imag_d = rd_load ? mem_im[rd_sel][rd_addr] : dout_imag_q;
  end

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      w_state_q    <= W_IDLE;
      r_state_q    <= R_IDLE;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      full_q       <= '0;
      ovf_q        <= 1'b0;
      sof_err_q    <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_sof_q   <= 1'b0;
      dout_eof_q   <= 1'b0;
      dout_real_q  <= '0;
      dout_imag_q  <= '0;
    end else begin
      w_state_q    <= w_state_d;
      r_state_q    <= r_state_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      full_q       <= full_d;
      ovf_q        <= ovf_d;
      sof_err_q    <= sof_err_d;
      dout_valid_q <= dout_valid_d;
      dout_sof_q   <= dout_sof_d;
      dout_eof_q   <= dout_eof_d;
      dout_real_q  <= dout_real_d;
      dout_imag_q  <= dout_imag_d;
    end
  end

  // NOTE: bank storage has no reset; the full flags guarantee an entry is written before it is read.
  always_ff @(posedge sys_clk_i) begin
    if (wr_en) begin
      mem_re[wr_bank_q][wr_addr] <= din_real_i;
      mem_im[wr_bank_q][wr_addr] <= din_imag_i;
    end
  end

  assign dout_valid_o = dout_valid_q;
  assign dout_sof_o   = dout_sof_q;
  assign dout_eof_o   = dout_eof_q;
  assign dout_real_o  = dout_real_q;
  assign dout_imag_o  = dout_imag_q;
  assign ovf_o        = ovf_q;
  assign sof_err_o    = sof_err_q;

endmodule

// File: tb/tb_fft_n64_digit_reverse_buf.sv
// Directed bench for the digit-reverse reorder buffer: latency, ordering, overflow,
// mid-frame sof recovery, backpressure stability and asynchronous reset.
module tb_fft_n64_digit_reverse_buf;

  localparam int DW = 33;

  logic sys_clk = 1'b0;
  logic rst;
  logic din_valid, din_sof, dout_ready;
  logic signed [DW-1:0] din_real, din_imag;
  logic dout_valid, dout_sof, dout_eof, ovf, sof_err;
  logic signed [DW-1:0] dout_real, dout_imag;

  fft_n64_digit_reverse_buf #(.DATA_WIDTH(DW)) dut (
    .sys_clk_i   (sys_clk),
    .rst_i       (rst),
    .din_valid_i (din_valid),
    .din_sof_i   (din_sof),
    .din_real_i  (din_real),
    .din_imag_i  (din_imag),
    .dout_valid_o(dout_valid),
    .dout_ready_i(dout_ready),
    .dout_sof_o  (dout_sof),
    .dout_eof_o  (dout_eof),
    .dout_real_o (dout_real),
    .dout_imag_o (dout_imag),
    .ovf_o       (ovf),
    .sof_err_o   (sof_err)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    logic sof;
    logic eof;
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } rec_t;

  rec_t rec[$];
  int   ovf_cyc[$];
  int   serr_cyc[$];
  int   stab_err = 0;
  logic p_valid = 1'b0, p_ready = 1'b0, p_sof = 1'b0, p_eof = 1'b0;
  logic signed [DW-1:0] p_re = '0, p_im = '0;

  // Output monitor on the falling edge: records handshakes and pulse cycles,
  // and flags any output change while a stalled sample is pending.
  always @(negedge sys_clk) begin
    if (rst) begin
      p_valid <= 1'b0;
    end else begin
      if (p_valid && !p_ready &&
          !(dout_valid === 1'b1 && dout_sof === p_sof && dout_eof === p_eof &&
            dout_real === p_re && dout_imag === p_im))
        stab_err <= stab_err + 1;
      if (dout_valid && dout_ready) begin
        rec_t r;
        r.cyc = cyc; r.sof = dout_sof; r.eof = dout_eof; r.re = dout_real; r.im = dout_imag;
        rec.push_back(r);
      end
      if (ovf) ovf_cyc.push_back(cyc);
      if (sof_err) serr_cyc.push_back(cyc);
      p_valid <= dout_valid;
      p_ready <= dout_ready;
      p_sof   <= dout_sof;
      p_eof   <= dout_eof;
      p_re    <= dout_real;
      p_im    <= dout_imag;
    end
  end

  int vectors = 0;
  int errs    = 0;
  bit rnd_ready = 1'b0;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Bin k holds sample n whose base-4 digits are those of k in reverse order.
  function automatic int bin_src(input int k);
    return (k % 4) * 16 + ((k / 4) % 4) * 4 + (k / 16);
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
    din_valid = 1'b0;
    din_sof   = 1'b0;
    if (rnd_ready) dout_ready = ($urandom_range(0, 1) == 1);
  endtask

  task automatic send(input int nsamp, input int base, output int sof_c);
    sof_c = -1;
    for (int n = 0; n < nsamp; n++) begin
      tick();
      din_valid = 1'b1;
      din_sof   = (n == 0);
      din_real  = DW'(base + n);
      din_imag  = DW'(-(base + n));
      if (n == 0) sof_c = cyc;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_recs(input int n, input int budget);
    int i = 0;
    while (rec.size() < n && i < budget) begin
      tick();
      i++;
    end
  endtask

  task automatic clear_logs();
    rec.delete();
    ovf_cyc.delete();
    serr_cyc.delete();
  endtask

  task automatic check_frame(input string tag, input int start, input int base);
    for (int k = 0; k < 64 && start + k < rec.size(); k++) begin
      int v;
      v = base + bin_src(k);
      check($sformatf("%s_re[%0d]", tag, k), rec[start + k].re, v);
      check($sformatf("%s_im[%0d]", tag, k), rec[start + k].im, -v);
      check($sformatf("%s_sof[%0d]", tag, k), rec[start + k].sof, (k == 0));
      check($sformatf("%s_eof[%0d]", tag, k), rec[start + k].eof, (k == 63));
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_valid"}, dout_valid, 0);
    check({tag, "_sof"}, dout_sof, 0);
    check({tag, "_eof"}, dout_eof, 0);
    check({tag, "_real"}, dout_real, 0);
    check({tag, "_imag"}, dout_imag, 0);
    check({tag, "_ovf"}, ovf, 0);
    check({tag, "_sof_err"}, sof_err, 0);
  endtask

  initial begin
    int s0, s1, s2;
    rst        = 1'b1;
    din_valid  = 1'b0;
    din_sof    = 1'b0;
    din_real   = '0;
    din_imag   = '0;
    dout_ready = 1'b1;

    // Reset state
    #2;
    check_quiet("reset");
    idle(3);
    rst = 1'b0;
    idle(3);
    clear_logs();

    // Single ramp frame, ready held high
    send(64, 0, s0);
    wait_recs(64, 200);
    idle(10);
    check("s1_count", rec.size(), 64);
    if (rec.size() > 0) check("s1_first_cyc", rec[0].cyc - s0, 65);
    if (rec.size() == 64) begin
      check("s1_last_cyc", rec[63].cyc - s0, 128);
      check("s1_k1", rec[1].re, 16);
      check("s1_k2", rec[2].re, 32);
      check("s1_k3", rec[3].re, 48);
      check("s1_k4", rec[4].re, 4);
      check("s1_k63", rec[63].re, 63);
    end
    check_frame("s1", 0, 0);
    clear_logs();

    // Three back-to-back frames
    send(64, 1000, s0);
    send(64, 2000, s1);
    send(64, 3000, s2);
    wait_recs(192, 400);
    idle(10);
    check("s2_count", rec.size(), 192);
    for (int i = 0; i < rec.size(); i++)
      check($sformatf("s2_cyc[%0d]", i), rec[i].cyc - s0, 65 + i);
    check_frame("s2f1", 0, 1000);
    check_frame("s2f2", 64, 2000);
    check_frame("s2f3", 128, 3000);
    check("s2_ovf", ovf_cyc.size(), 0);
    clear_logs();

    // Random ready on a single frame
    rnd_ready = 1'b1;
    send(64, 0, s0);
    wait_recs(64, 600);
    rnd_ready  = 1'b0;
    dout_ready = 1'b1;
    idle(10);
    check("s3_count", rec.size(), 64);
    check_frame("s3", 0, 0);
    clear_logs();

    // Ready low while three frames arrive: third frame is dropped
    dout_ready = 1'b0;
    send(64, 4000, s0);
    send(64, 5000, s1);
    send(64, 6000, s2);
    idle(10);
    check("s4_stalled", rec.size(), 0);
    check("s4_ovf_count", ovf_cyc.size(), 1);
    if (ovf_cyc.size() > 0) check("s4_ovf_cyc", ovf_cyc[0] - s2, 1);
    dout_ready = 1'b1;
    wait_recs(128, 400);
    idle(100);
    check("s4_count", rec.size(), 128);
    check_frame("s4f1", 0, 4000);
    check_frame("s4f2", 64, 5000);
    clear_logs();

    // sof reasserted at n=20, then a clean frame
    send(20, 7000, s0);
    send(64, 8000, s1);
    wait_recs(64, 200);
    idle(100);
    check("s5_serr_count", serr_cyc.size(), 1);
    if (serr_cyc.size() > 0) check("s5_serr_cyc", serr_cyc[0] - s1, 1);
    check("s5_ovf", ovf_cyc.size(), 0);
    check("s5_count", rec.size(), 64);
    if (rec.size() > 0) check("s5_first_cyc", rec[0].cyc - s1, 65);
    check_frame("s5", 0, 8000);
    clear_logs();

    // Asynchronous reset mid-readout, then a fresh frame
    send(64, 9000, s0);
    wait_recs(10, 200);
    check("s6_pre_valid", dout_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check_quiet("s6_async");
    idle(3);
    rst = 1'b0;
    idle(3);
    clear_logs();
    send(64, 10000, s0);
    wait_recs(64, 200);
    idle(10);
    check("s6_count", rec.size(), 64);
    if (rec.size() > 0) check("s6_first_cyc", rec[0].cyc - s0, 65);
    check_frame("s6", 0, 10000);

    check("stability", stab_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/fft_n64_digit_reverse_buf.md
# fft_n64_digit_reverse_buf

Ping-pong reorder buffer placed directly downstream of the 64-point radix-4 FFT core. It accepts FFT output samples in radix-4 digit-reversed order, one complex sample per cycle and without backpressure, and stores them into one of two 64-entry banks at digit-reversed addresses. It then streams each completed frame out in natural bin order (k = 0..63) over a valid/ready interface.

## Interface
- DATA_WIDTH, default 33: width of each real/imag component. This matches the FFT core output width of 32+1.

Ports:
- sys_clk_i  in  1  sole clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- din_valid_i  in  1  input sample strobe; there is no ready signal toward the FFT.
- din_sof_i  in  1  marks the first sample of a frame; qualified by din_valid_i.
- din_real_i  in  DATA_WIDTH  signed real part.
- din_imag_i  in  DATA_WIDTH  signed imaginary part.
- dout_valid_o  out  1  output sample valid.
- dout_ready_i  in  1  downstream ready.
- dout_sof_o  out  1  high with bin k=0.
- dout_eof_o  out  1  high with bin k=63.
- dout_real_o  out  DATA_WIDTH  signed real part, registered.
- dout_imag_o  out  DATA_WIDTH  signed imaginary part, registered.
- ovf_o  out  1  one-cycle pulse: an incoming frame was dropped because no bank was free.
- sof_err_o  out  1  one-cycle pulse: din_sof_i arrived mid-frame.

## Operation
- Storage: two banks (bank 0 and bank 1), each 64 x (real, imag), implemented as register arrays. Bank contents are not reset. Each bank has a full flag; both flags reset to 0.
- Address mapping: the n-th sample of a frame (n = 0..63, 6-bit n[5:0]) is written to address {n[1:0], n[3:2], n[5:4]}. This swaps the base-4 digits.
- Write FSM:
  - States: W_IDLE and W_FILL. Registers: wr_cnt (6 bits) and wr_bank (1 bit).
  - W_IDLE:
    - A sample with din_valid_i and no din_sof_i is discarded silently.
    - A sample with din_valid_i and din_sof_i is checked against bank wr_bank. The bank is free if its full flag is 0, or if the read side accepts that bank's final sample (k=63) on the same edge. Release takes priority over the write.
    - Bank free: write sample n=0, set wr_cnt=1, go to W_FILL.
    - Bank not free: drop the whole frame, pulse ovf_o, stay in W_IDLE.
  - W_FILL:
    - Each valid sample is written at address digitrev(wr_cnt), then wr_cnt increments.
    - On the write of n=63: set full[wr_bank], toggle wr_bank, go to W_IDLE.
    - din_sof_i with din_valid_i in W_FILL: pulse sof_err_o, discard the partial frame, and write this sample as n=0 of the same bank with wr_cnt=1.
    - Gaps in din_valid_i are allowed and pause the fill.
- Read FSM:
  - States: R_IDLE and R_STREAM. Registers: rd_cnt (6 bits) and rd_bank (1 bit).
  - R_IDLE: when full[rd_bank]=1, load the output registers with address 0, assert dout_valid_o and dout_sof_o, set rd_cnt=1, go to R_STREAM.
  - R_STREAM, on each handshake (dout_valid_o && dout_ready_i):
    - If the accepted sample was k=63: clear full[rd_bank] and toggle rd_bank. If the other bank is already full, load its k=0 on the same edge (no bubble). Otherwise deassert dout_valid_o and go to R_IDLE.
    - For any other accepted sample: load address rd_cnt and increment rd_cnt.
  - dout_eof_o is high exactly when the presented sample is k=63.
- While dout_valid_o is high and dout_ready_i is low, all dout_* outputs hold stable.

## Timing
- Reset values: dout_valid_o, dout_sof_o, dout_eof_o, dout_real_o, dout_imag_o, ovf_o and sof_err_o are all 0. Both FSMs are in IDLE, all counters are 0, wr_bank=rd_bank=0, both full flags are 0.
- An asserted reset mid-operation clears all of the above immediately, regardless of the clock. Any partial or pending frames are lost.
- Latency: if the last input sample (n=63) is presented in cycle c, full is set at the end of cycle c. The read side loads during cycle c+1, so dout_valid_o with k=0 is visible in cycle c+2.
- Throughput: 1 sample per cycle in each direction. With dout_ready_i held high, continuous back-to-back frames flow with no gaps and no drops.
- ovf_o and sof_err_o are registered. Each pulses in the cycle after the offending input sample.
- Write and read sides operate on different banks, so there are no port conflicts. The only interaction between them is the full-flag release rule described above.

## Test plan
- Single frame, ramp input with real=n and imag=-n for n=0..63, dout_ready_i=1:
  - Outputs appear in cycles 65..128 (sof presented in cycle 0).
  - Bin k carries real=digitrev(k): k=1 gives 16, k=2 gives 32, k=3 gives 48, k=4 gives 4, k=63 gives 63. Imaginary parts are the negation.
  - dout_sof_o is high with k=0 and dout_eof_o is high with k=63.
- Three back-to-back frames, dout_ready_i=1:
  - 192 consecutive valid outputs with no gaps.
  - dout_sof_o in cycles 65, 129 and 193; ovf_o never pulses.
- Random dout_ready_i at 50% duty on a single frame: output sequence is identical to the first scenario, and outputs are stable whenever valid is high and ready is low.
- dout_ready_i=0 while three frames are sent:
  - Frames 1 and 2 are stored; ovf_o pulses once, at frame 3's sof.
  - After ready is raised, exactly 128 outputs appear (frames 1 and 2 only).
- din_sof_i reasserted at n=20, followed by a clean 64-sample frame: sof_err_o pulses once, and the output equals the clean frame only.
- rst_i asserted asynchronously mid-readout:
  - All outputs go to 0 immediately.
  - After release, a new frame produces a correct output with the first-scenario latency.
